// File: rtl/video_mode_detect_pkg.sv
// ============================================================================
// Module   : video_mode_pkg
// Brief    : Shared types and constants for the video mode detector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package video_mode_pkg;

  localparam int MODE_ID_W = 4;

  typedef enum logic [1:0] {
    NO_SIGNAL = 2'd0,
    ACQUIRE   = 2'd1,
    LOCKED    = 2'd2
  } state_t;

  localparam logic [MODE_ID_W-1:0] MODE_UNKNOWN = 4'd0;
  localparam logic [MODE_ID_W-1:0] MODE_VGA     = 4'd1;
  localparam logic [MODE_ID_W-1:0] MODE_SVGA    = 4'd2;
  localparam logic [MODE_ID_W-1:0] MODE_XGA     = 4'd3;
  localparam logic [MODE_ID_W-1:0] MODE_720P    = 4'd4;
  localparam logic [MODE_ID_W-1:0] MODE_SXGA    = 4'd5;
  localparam logic [MODE_ID_W-1:0] MODE_1080P   = 4'd6;

  localparam logic [15:0] VGA_H   = 16'd640;
  localparam logic [15:0] VGA_V   = 16'd480;
  localparam logic [15:0] SVGA_H  = 16'd800;
  localparam logic [15:0] SVGA_V  = 16'd600;
  localparam logic [15:0] XGA_H   = 16'd1024;
  localparam logic [15:0] XGA_V   = 16'd768;
  localparam logic [15:0] P720_H  = 16'd1280;
  localparam logic [15:0] P720_V  = 16'd720;
  localparam logic [15:0] SXGA_H  = 16'd1280;
  localparam logic [15:0] SXGA_V  = 16'd1024;
  localparam logic [15:0] P1080_H = 16'd1920;
  localparam logic [15:0] P1080_V = 16'd1080;

endpackage

`default_nettype wire

// File: rtl/video_mode_detect_if.sv
// ============================================================================
// Module   : video_mode_detect_if
// Brief    : Measurement inputs and mode status outputs of the detector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface video_mode_detect_if;
  import video_mode_pkg::*;

  logic [15:0]          h_active;
  logic                 ha_updated;
  logic [15:0]          v_active;
  logic                 va_updated;
  logic [7:0]           fps;
  logic                 fps_valid;
  logic                 mode_locked;
  logic [MODE_ID_W-1:0] mode_id;
  logic [15:0]          h_res;
  logic [15:0]          v_res;
  logic [7:0]           fps_out;
  logic                 signal_lost;
  logic                 mode_changed;

  modport master (
    output h_active, ha_updated, v_active, va_updated, fps, fps_valid,
    input  mode_locked, mode_id, h_res, v_res, fps_out, signal_lost, mode_changed
  );

  modport slave (
    input  h_active, ha_updated, v_active, va_updated, fps, fps_valid,
    output mode_locked, mode_id, h_res, v_res, fps_out, signal_lost, mode_changed
  );

endinterface

`default_nettype wire

// File: rtl/video_mode_detect_lut.sv
// ============================================================================
// Module   : video_mode_lut
// Brief    : Combinational resolution -> mode index lookup; 0 for unknown.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module video_mode_lut
  import video_mode_pkg::*;
(
  input  wire logic [15:0]          h,
  input  wire logic [15:0]          v,
  output      logic [MODE_ID_W-1:0] mode_id
);

  always_comb begin
    mode_id = MODE_UNKNOWN;
    case ({h, v})
      {VGA_H,   VGA_V}   : mode_id = MODE_VGA;
      {SVGA_H,  SVGA_V}  : mode_id = MODE_SVGA;
      {XGA_H,   XGA_V}   : mode_id = MODE_XGA;
      {P720_H,  P720_V}  : mode_id = MODE_720P;
      {SXGA_H,  SXGA_V}  : mode_id = MODE_SXGA;
      {P1080_H, P1080_V} : mode_id = MODE_1080P;
      default            : mode_id = MODE_UNKNOWN;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/video_mode_detect.sv
// ============================================================================
// Module   : video_mode_detect
// Brief    : Qualifies per-frame resolution measurements, locks and classifies
//            the video mode and flags loss of signal.
// Options  : VIDEO_MODE_DETECT_FPS_CHECK_EN - gate lock on a minimum frame rate
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module video_mode_detect
  import video_mode_pkg::*;
#(
  parameter int unsigned STABLE_FRAMES = 4,
  parameter int unsigned MISMATCH_TOL  = 2,
  parameter int unsigned LOSS_TIMEOUT  = 4_000_000,
  parameter int unsigned MIN_FPS       = 20
) (
  input wire logic          pxl_clk,
  input wire logic          rst,
  video_mode_detect_if.slave vif
);

  if (STABLE_FRAMES < 1 || STABLE_FRAMES > 15) begin : g_bad_stable_frames
    $error("STABLE_FRAMES must be within 1..15");
  end
  if (MISMATCH_TOL < 1 || MISMATCH_TOL > 15) begin : g_bad_mismatch_tol
    $error("MISMATCH_TOL must be within 1..15");
  end
  if (LOSS_TIMEOUT < 1) begin : g_bad_loss_timeout
    $error("LOSS_TIMEOUT must be at least 1");
  end
  if (MIN_FPS > 255) begin : g_bad_min_fps
    $error("MIN_FPS must fit in 8 bits");
  end

  localparam logic [3:0]  C_STABLE  = 4'(STABLE_FRAMES);
  localparam logic [3:0]  C_MIS_TOL = 4'(MISMATCH_TOL);
  localparam logic [31:0] C_TO_LAST = 32'(LOSS_TIMEOUT - 1);

  state_t               r_state, w_next_state;
  logic [15:0]          r_h_cap;
  logic [15:0]          r_ref_h, r_ref_v, w_next_ref_h, w_next_ref_v;
  logic [3:0]           r_stable_cnt, w_next_stable_cnt;
  logic [3:0]           r_mis_cnt, w_next_mis_cnt;
  logic [31:0]          r_to_cnt;
  logic [7:0]           r_fps;
  logic                 r_mode_changed;

  logic [15:0]          w_sample_h;
  logic                 w_valid, w_match, w_timeout;
  logic [3:0]           w_stable_inc, w_mis_inc;
  logic [MODE_ID_W-1:0] w_lut_id;

  // A width strobe coinciding with the frame strobe must win over the stale capture.
  assign w_sample_h   = vif.ha_updated ? vif.h_active : r_h_cap;
  assign w_valid      = (w_sample_h != 16'd0) && (vif.v_active != 16'd0);
  assign w_match      = w_valid && (w_sample_h == r_ref_h) && (vif.v_active == r_ref_v);
  assign w_timeout    = !vif.va_updated && (r_to_cnt == C_TO_LAST);
  assign w_stable_inc = (r_stable_cnt == 4'hF) ? 4'hF : r_stable_cnt + 4'd1;
  assign w_mis_inc    = (r_mis_cnt == 4'hF) ? 4'hF : r_mis_cnt + 4'd1;

`ifdef VIDEO_MODE_DETECT_FPS_CHECK_EN
  logic [7:0] w_fps_last;
  logic       w_fps_ok;
  assign w_fps_last = vif.fps_valid ? vif.fps : r_fps;
  assign w_fps_ok   = (w_fps_last >= 8'(MIN_FPS));
`endif

  video_mode_lut u_lut (
    .h       (r_ref_h),
    .v       (r_ref_v),
    .mode_id (w_lut_id)
  );

  always_ff @(posedge pxl_clk) begin
    if (rst) begin
      r_h_cap  <= 16'd0;
      r_to_cnt <= 32'd0;
      r_fps    <= 8'd0;
    end else begin
      if (vif.ha_updated) r_h_cap <= vif.h_active;
      if (vif.fps_valid)  r_fps   <= vif.fps;
      if (vif.va_updated)            r_to_cnt <= 32'd0;
      else if (r_to_cnt != 32'hFFFF_FFFF) r_to_cnt <= r_to_cnt + 32'd1;
    end
  end

  // State register together with the FSM-owned reference and counters.
  always_ff @(posedge pxl_clk) begin
    if (rst) begin
      r_state        <= NO_SIGNAL;
      r_ref_h        <= 16'd0;
      r_ref_v        <= 16'd0;
      r_stable_cnt   <= 4'd0;
      r_mis_cnt      <= 4'd0;
      r_mode_changed <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_ref_h        <= w_next_ref_h;
      r_ref_v        <= w_next_ref_v;
      r_stable_cnt   <= w_next_stable_cnt;
      r_mis_cnt      <= w_next_mis_cnt;
      r_mode_changed <= (w_next_state == LOCKED) != (r_state == LOCKED);
    end
  end

  always_comb begin
    w_next_state      = r_state;
    w_next_ref_h      = r_ref_h;
    w_next_ref_v      = r_ref_v;
    w_next_stable_cnt = r_stable_cnt;
    w_next_mis_cnt    = r_mis_cnt;
    if (w_timeout && r_state != NO_SIGNAL) begin
      w_next_state      = NO_SIGNAL;
      w_next_ref_h      = 16'd0;
      w_next_ref_v      = 16'd0;
      w_next_stable_cnt = 4'd0;
      w_next_mis_cnt    = 4'd0;
    end else begin
      case (r_state)
        NO_SIGNAL: begin
          if (vif.va_updated && w_valid) begin
            w_next_state      = ACQUIRE;
            w_next_ref_h      = w_sample_h;
            w_next_ref_v      = vif.v_active;
            w_next_stable_cnt = 4'd1;
            w_next_mis_cnt    = 4'd0;
          end
        end
        ACQUIRE: begin
          if (vif.va_updated) begin
            if (w_match) begin
              w_next_stable_cnt = w_stable_inc;
            end else if (w_valid) begin
              w_next_ref_h      = w_sample_h;
              w_next_ref_v      = vif.v_active;
              w_next_stable_cnt = 4'd1;
            end else begin
              w_next_ref_h      = 16'd0;
              w_next_ref_v      = 16'd0;
              w_next_stable_cnt = 4'd0;
            end
          end
          if (w_next_stable_cnt >= C_STABLE) begin
`ifdef VIDEO_MODE_DETECT_FPS_CHECK_EN
            if (w_fps_ok) begin
              w_next_state   = LOCKED;
              w_next_mis_cnt = 4'd0;
            end else begin
              w_next_stable_cnt = C_STABLE;
            end
`else
            w_next_state   = LOCKED;
            w_next_mis_cnt = 4'd0;
`endif
          end
        end
        LOCKED: begin
          if (vif.va_updated) begin
            if (w_match) begin
              w_next_mis_cnt = 4'd0;
            end else if (w_mis_inc >= C_MIS_TOL) begin
              w_next_state      = ACQUIRE;
              w_next_ref_h      = w_valid ? w_sample_h : 16'd0;
              w_next_ref_v      = w_valid ? vif.v_active : 16'd0;
              w_next_stable_cnt = w_valid ? 4'd1 : 4'd0;
              w_next_mis_cnt    = 4'd0;
            end else begin
              w_next_mis_cnt = w_mis_inc;
            end
          end
`ifdef VIDEO_MODE_DETECT_FPS_CHECK_EN
          if (vif.fps_valid && (vif.fps < 8'(MIN_FPS))) begin
            w_next_state      = ACQUIRE;
            w_next_stable_cnt = 4'd0;
            w_next_mis_cnt    = 4'd0;
          end
`endif
        end
        default: begin
          w_next_state = NO_SIGNAL;
        end
      endcase
    end
  end

  // The reference is frozen while locked, so the resolution outputs follow it directly.
  always_comb begin
    vif.mode_locked  = (r_state == LOCKED);
    vif.signal_lost  = (r_state == NO_SIGNAL);
    vif.h_res        = (r_state == LOCKED) ? r_ref_h : 16'd0;
    vif.v_res        = (r_state == LOCKED) ? r_ref_v : 16'd0;
    vif.mode_id      = (r_state == LOCKED) ? w_lut_id : MODE_UNKNOWN;
    vif.fps_out      = r_fps;
    vif.mode_changed = r_mode_changed;
  end

endmodule

`default_nettype wire

// File: doc/video_mode_detect.md
Name: video_mode_detect

Overview:
- Consumes the per-line/per-frame measurements of the upstream timing checker: active width, active height and frames-per-second, each with its update strobe.
- Qualifies the measurements over several frames and declares a stable, locked video mode.
- Classifies the locked resolution against a fixed table of known modes.
- Detects loss of video; its outputs drive the scaler/output-timing selection and status LEDs.

Parameters:
- STABLE_FRAMES, 4: consecutive identical frames required to lock (1..15).
- MISMATCH_TOL, 2: consecutive differing frames tolerated while locked before unlock (1..15).
- LOSS_TIMEOUT, 4_000_000: pxl_clk cycles without va_updated that declare signal loss.
- MIN_FPS, 20: minimum fps for lock; used only with the optional feature.

Ports:
- pxl_clk  in  1  pixel clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- h_active  in  16  measured active pixels per line.
- ha_updated  in  1  one-cycle strobe; h_active is valid this cycle.
- v_active  in  16  measured active lines per frame.
- va_updated  in  1  one-cycle strobe, one per frame; v_active is valid this cycle.
- fps  in  8  measured frame rate.
- fps_valid  in  1  one-cycle strobe, about 1 Hz.
- mode_locked  out  1  high while in LOCKED.
- mode_id  out  4  table index; 0 means unknown or not locked.
- h_res  out  16  locked width; 0 when not locked.
- v_res  out  16  locked height; 0 when not locked.
- fps_out  out  8  last fps sample.
- signal_lost  out  1  high in NO_SIGNAL.
- mode_changed  out  1  one-cycle pulse on every entry to or exit from LOCKED.

Behaviour:
- Reset values:
  - state = NO_SIGNAL.
  - signal_lost = 1.
  - All other outputs = 0; all counters and captures = 0.
- Width capture:
  - h_cap loads h_active on each ha_updated.
  - When ha_updated and va_updated coincide, the frame sample uses the new h_active.
- Frame sample:
  - Taken on each va_updated as the pair {h_cap, v_active}.
  - A sample is invalid if either value is 0.
  - A sample "matches" if it is valid and equals ref = {ref_h, ref_v}.
- Timeout:
  - The timeout counter clears on va_updated and otherwise increments, saturating.
  - Timeout fires when count == LOSS_TIMEOUT-1 with no va_updated in that cycle.
  - Timeout has priority over all other state transitions.
- FSM, all transitions registered (outputs change the cycle after the triggering strobe):
  - NO_SIGNAL:
    - Valid sample -> ACQUIRE with ref = sample and stable_cnt = 1.
    - Invalid sample -> stay.
  - ACQUIRE:
    - Matching sample -> stable_cnt + 1.
    - Non-matching valid sample -> ref = sample, stable_cnt = 1.
    - Invalid sample -> stable_cnt = 0 and ref cleared.
    - stable_cnt reaching STABLE_FRAMES -> LOCKED, in the same cycle the count is reached.
    - Timeout -> NO_SIGNAL.
  - LOCKED:
    - Matching sample -> mis_cnt = 0.
    - Non-matching sample (valid or invalid) -> mis_cnt + 1.
    - mis_cnt reaching MISMATCH_TOL -> ACQUIRE with ref = latest sample and stable_cnt = 1 if valid, else 0.
    - Timeout -> NO_SIGNAL.
- Locked outputs: on entry to LOCKED, h_res, v_res and mode_id load from ref and the LUT. In any other state they read 0.
- mode_changed: asserted for exactly one cycle, the cycle after the state register enters or leaves LOCKED.
- fps_out: loads fps on every fps_valid, in any state. It is not cleared by signal loss.
- Mode table, h×v -> id:
  - 640×480 = 1
  - 800×600 = 2
  - 1024×768 = 3
  - 1280×720 = 4
  - 1280×1024 = 5
  - 1920×1080 = 6
  - Anything else = 0; the block still locks on unknown modes.
- Counters are 4 bits and saturate; the timeout counter is 32 bits.
- Reset mid-frame returns to the reset values in the next cycle; partially accumulated counts are discarded.

Optional Feature:
- Macro: VIDEO_MODE_DETECT_FPS_CHECK_EN.
- When defined:
  - ACQUIRE -> LOCKED additionally requires that the last fps sample is >= MIN_FPS. Until that holds, ACQUIRE holds stable_cnt at STABLE_FRAMES.
  - In LOCKED, an fps_valid with fps < MIN_FPS forces ACQUIRE with stable_cnt = 0.
- When undefined: fps only updates fps_out and plays no part in locking.

Decomposition:
- Package video_mode_pkg holds:
  - The state enum {NO_SIGNAL, ACQUIRE, LOCKED}.
  - MODE_ID_W = 4.
  - Mode ID constants and the h/v table constants.
- Sub-module video_mode_lut: purely combinational h,v -> mode_id lookup, instantiated once on ref.

Test Plan:
- 5 frames of 1920×1080 (ha_updated with 1920, then va_updated with 1080), STABLE_FRAMES=4 -> mode_locked rises the cycle after the 4th va_updated; mode_id = 6; h_res = 1920; mode_changed pulses once.
- While locked at 1280×720, one frame at 1280×719 then normal frames -> stays locked, no mode_changed. Two consecutive 1280×719 frames -> unlock and mode_changed pulse; relock as 1280×719 with mode_id = 0 after 4 frames.
- Stop va_updated with LOSS_TIMEOUT=1000 -> signal_lost = 1 exactly 1000 cycles after the last strobe; mode_locked = 0; mode_changed pulses.
- ha_updated(800) and va_updated(600) in the same cycle, repeated 4 times -> lock with mode_id = 2.
- Frames with h = 0 interleaved in ACQUIRE -> stable_cnt resets and no lock until 4 consecutive valid frames.
- With VIDEO_MODE_DETECT_FPS_CHECK_EN and fps_valid carrying 15 -> no lock after 4 good frames. fps_valid carrying 30 -> lock the next cycle.
